// File: rtl/alpha68k_irq_latch.sv
// Interrupt, sound-command latch and frame watchdog state behind the Alpha68k address decoder.
// Optional watchdog is built only when ALPHA68K_WATCHDOG_EN is defined; otherwise watchdog_rst is tied low.
module alpha68k_irq_latch #(
  parameter int WDOG_FRAMES = 8,
  parameter int WDOG_PULSE  = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       vblank,
  input  logic       mcu_irq_req,
  input  logic [7:0] m68k_din,
  input  logic       m68k_latch_cs,
  input  logic       vbl_int_clr_cs,
  input  logic       cpu_int_clr_cs,
  input  logic       watchdog_clr_cs,
  input  logic       z80_latch_clr_cs,
  output logic [2:0] m68k_ipl_n,
  output logic       vbl_irq,
  output logic       mcu_irq,
  output logic [7:0] sound_latch,
  output logic       z80_int_n,
  output logic       watchdog_rst
);

  // state   | meaning
  // WD_IDLE | counting vblank edges since the last watchdog clear
  // WD_FIRE | driving watchdog_rst, pulse timer counting down

  logic vblank_d, m68k_latch_d, vbl_int_clr_d, cpu_int_clr_d, z80_latch_clr_d;
  logic vbl_evt, latch_evt, vbl_clr_evt, cpu_clr_evt, z80_clr_evt;
  logic pending;
  logic [1:0] irq_level;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vblank_d        <= 1'b0;
      m68k_latch_d    <= 1'b0;
      vbl_int_clr_d   <= 1'b0;
      cpu_int_clr_d   <= 1'b0;
      z80_latch_clr_d <= 1'b0;
    end else begin
      vblank_d        <= vblank;
      m68k_latch_d    <= m68k_latch_cs;
      vbl_int_clr_d   <= vbl_int_clr_cs;
      cpu_int_clr_d   <= cpu_int_clr_cs;
      z80_latch_clr_d <= z80_latch_clr_cs;
    end
  end

  assign vbl_evt     = vblank & ~vblank_d;
  assign latch_evt   = m68k_latch_cs & ~m68k_latch_d;
  assign vbl_clr_evt = vbl_int_clr_cs & ~vbl_int_clr_d;
  assign cpu_clr_evt = cpu_int_clr_cs & ~cpu_int_clr_d;
  assign z80_clr_evt = z80_latch_clr_cs & ~z80_latch_clr_d;

  assign irq_level = mcu_irq ? 2'd2 : (vbl_irq ? 2'd1 : 2'd0);

  // Set terms are tested first so a coincident clear loses.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vbl_irq     <= 1'b0;
      mcu_irq     <= 1'b0;
      m68k_ipl_n  <= 3'b111;
      sound_latch <= 8'h00;
      pending     <= 1'b0;
      z80_int_n   <= 1'b1;
    end else begin
      if (vbl_evt)          vbl_irq <= 1'b1;
      else if (vbl_clr_evt) vbl_irq <= 1'b0;
      if (mcu_irq_req)      mcu_irq <= 1'b1;
      else if (cpu_clr_evt) mcu_irq <= 1'b0;
      m68k_ipl_n <= ~{1'b0, irq_level};
      if (latch_evt) begin
        sound_latch <= m68k_din;
        pending     <= 1'b1;
      end else if (z80_clr_evt) begin
        pending <= 1'b0;
      end
      z80_int_n <= ~pending;
    end
  end

`ifdef ALPHA68K_WATCHDOG_EN
  typedef enum logic {WD_IDLE, WD_FIRE} wd_state_t;

  localparam logic [3:0] FRAMES_TC  = 4'(WDOG_FRAMES);
  localparam logic [4:0] PULSE_LOAD = 5'(WDOG_PULSE - 1);

  wd_state_t  wd_state, wd_state_nxt;
  logic [3:0] frame_cnt, frame_nxt, frame_inc;
  logic [4:0] pulse_cnt, pulse_nxt;
  logic       watchdog_clr_d, wdog_clr_evt;

  assign wdog_clr_evt = watchdog_clr_cs & ~watchdog_clr_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wd_state       <= WD_IDLE;
      frame_cnt      <= 4'd0;
      pulse_cnt      <= 5'd0;
      watchdog_clr_d <= 1'b0;
    end else begin
      wd_state       <= wd_state_nxt;
      frame_cnt      <= frame_nxt;
      pulse_cnt      <= pulse_nxt;
      watchdog_clr_d <= watchdog_clr_cs;
    end
  end

  always_comb begin
    wd_state_nxt = wd_state;
    frame_nxt    = frame_cnt;
    pulse_nxt    = pulse_cnt;
    frame_inc    = (frame_cnt == 4'hF) ? frame_cnt : frame_cnt + 4'd1;
    case (wd_state)
      WD_IDLE: begin
        if (wdog_clr_evt) begin
          frame_nxt = 4'd0;
        end else if (vbl_evt) begin
          frame_nxt = frame_inc;
          if (frame_inc == FRAMES_TC) begin
            wd_state_nxt = WD_FIRE;
            pulse_nxt    = PULSE_LOAD;
          end
        end
      end
      WD_FIRE: begin
        // Pulse length is fixed once started; clears and vblank are ignored here.
        if (pulse_cnt == 5'd0) begin
          wd_state_nxt = WD_IDLE;
          frame_nxt    = 4'd0;
        end else begin
          pulse_nxt = pulse_cnt - 5'd1;
        end
      end
      default: wd_state_nxt = WD_IDLE;
    endcase
  end

  assign watchdog_rst = (wd_state == WD_FIRE);
`else
  logic unused_wdog;
  assign unused_wdog  = watchdog_clr_cs ^ (WDOG_FRAMES == 0) ^ (WDOG_PULSE == 0);
  assign watchdog_rst = 1'b0;
`endif

endmodule

// File: tb/tb_alpha68k_irq_latch.sv
// Scoreboard bench for alpha68k_irq_latch: directed test-plan sequences plus random strobes, checked
// against a behavioural model; watchdog expectations follow ALPHA68K_WATCHDOG_EN.
module tb_alpha68k_irq_latch;

  localparam int FRAMES = 8;
  localparam int PULSE  = 16;

  typedef struct packed {
    logic       vblank;
    logic       mcu_req;
    logic [7:0] din;
    logic       latch;
    logic       vclr;
    logic       cclr;
    logic       wclr;
    logic       zclr;
  } stim_t;

  typedef struct packed {
    logic [2:0] ipl_n;
    logic       vbl;
    logic       mcu;
    logic [7:0] latch;
    logic       zint_n;
    logic       wrst;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       vblank = 1'b0, mcu_irq_req = 1'b0;
  logic [7:0] m68k_din = 8'h00;
  logic       m68k_latch_cs = 1'b0, vbl_int_clr_cs = 1'b0, cpu_int_clr_cs = 1'b0;
  logic       watchdog_clr_cs = 1'b0, z80_latch_clr_cs = 1'b0;
  logic [2:0] m68k_ipl_n;
  logic       vbl_irq, mcu_irq, z80_int_n, watchdog_rst;
  logic [7:0] sound_latch;

  int checks = 0;
  int errors = 0;
  exp_t sb[$];

  stim_t      cur, prv;
  logic       m_vbl, m_mcu, m_pend, m_zint_n;
  logic [2:0] m_ipl_n;
  logic [7:0] m_latch;
  int         m_frames, m_fire;

  alpha68k_irq_latch #(.WDOG_FRAMES(FRAMES), .WDOG_PULSE(PULSE)) dut (
    .clk(clk), .reset(reset), .vblank(vblank), .mcu_irq_req(mcu_irq_req), .m68k_din(m68k_din),
    .m68k_latch_cs(m68k_latch_cs), .vbl_int_clr_cs(vbl_int_clr_cs), .cpu_int_clr_cs(cpu_int_clr_cs),
    .watchdog_clr_cs(watchdog_clr_cs), .z80_latch_clr_cs(z80_latch_clr_cs),
    .m68k_ipl_n(m68k_ipl_n), .vbl_irq(vbl_irq), .mcu_irq(mcu_irq), .sound_latch(sound_latch),
    .z80_int_n(z80_int_n), .watchdog_rst(watchdog_rst)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  // Monitor: one expected record per clock edge, compared just after the edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("ipl_n", {5'b0, m68k_ipl_n}, {5'b0, e.ipl_n});
        chk("vbl_irq", {7'b0, vbl_irq}, {7'b0, e.vbl});
        chk("mcu_irq", {7'b0, mcu_irq}, {7'b0, e.mcu});
        chk("sound_latch", sound_latch, e.latch);
        chk("z80_int_n", {7'b0, z80_int_n}, {7'b0, e.zint_n});
        chk("watchdog_rst", {7'b0, watchdog_rst}, {7'b0, e.wrst});
      end
    end
  end

  function automatic logic [2:0] level_of(input logic mcu, input logic vbl);
    int lvl;
    lvl = mcu ? 2 : (vbl ? 1 : 0);
    return 3'(7 - lvl);
  endfunction

  task automatic model_reset();
    prv = '0; m_vbl = 0; m_mcu = 0; m_pend = 0; m_zint_n = 1;
    m_ipl_n = 3'b111; m_latch = 8'h00; m_frames = 0; m_fire = 0;
  endtask

  task automatic model_step(input stim_t s);
    exp_t e;
    bit r_v, r_l, r_vc, r_cc, r_wc, r_zc;
    r_v  = s.vblank & !prv.vblank;
    r_l  = s.latch  & !prv.latch;
    r_vc = s.vclr   & !prv.vclr;
    r_cc = s.cclr   & !prv.cclr;
    r_wc = s.wclr   & !prv.wclr;
    r_zc = s.zclr   & !prv.zclr;
    m_ipl_n  = level_of(m_mcu, m_vbl);
    m_zint_n = !m_pend;
    if (r_v) m_vbl = 1; else if (r_vc) m_vbl = 0;
    if (s.mcu_req) m_mcu = 1; else if (r_cc) m_mcu = 0;
    if (r_l) begin m_latch = s.din; m_pend = 1; end
    else if (r_zc) m_pend = 0;
`ifdef ALPHA68K_WATCHDOG_EN
    if (m_fire > 0) begin
      m_fire--;
      if (m_fire == 0) m_frames = 0;
    end else if (r_wc) begin
      m_frames = 0;
    end else if (r_v) begin
      if (m_frames < 15) m_frames++;
      if (m_frames == FRAMES) m_fire = PULSE;
    end
`else
    m_fire = 0;
    m_frames = r_wc ? 0 : m_frames;
`endif
    prv = s;
    e.ipl_n = m_ipl_n; e.vbl = m_vbl; e.mcu = m_mcu; e.latch = m_latch;
    e.zint_n = m_zint_n; e.wrst = (m_fire > 0);
    sb.push_back(e);
  endtask

  task automatic drive(input stim_t s);
    vblank = s.vblank; mcu_irq_req = s.mcu_req; m68k_din = s.din;
    m68k_latch_cs = s.latch; vbl_int_clr_cs = s.vclr; cpu_int_clr_cs = s.cclr;
    watchdog_clr_cs = s.wclr; z80_latch_clr_cs = s.zclr;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      drive(cur);
      model_step(cur);
    end
  endtask

  task automatic frame();
    cur.vblank = 1; run(3);
    cur.vblank = 0; run(3);
  endtask

  task automatic check_reset_values();
    chk("rst ipl_n", {5'b0, m68k_ipl_n}, 8'h07);
    chk("rst vbl_irq", {7'b0, vbl_irq}, 8'h00);
    chk("rst mcu_irq", {7'b0, mcu_irq}, 8'h00);
    chk("rst sound_latch", sound_latch, 8'h00);
    chk("rst z80_int_n", {7'b0, z80_int_n}, 8'h01);
    chk("rst watchdog_rst", {7'b0, watchdog_rst}, 8'h00);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global timeout at %0t", $time);
    $fatal(1, "timeout");
  end

  initial begin
    cur = '0;
    model_reset();
    drive(cur);
    repeat (3) @(negedge clk);
    check_reset_values();
    reset = 1'b0;

    cur.vblank = 1; run(100); cur.vblank = 0; run(3);
    cur.vclr = 1; run(4); cur.vclr = 0; run(3);

    cur.vblank = 1; run(2); cur.vblank = 0; run(2);
    cur.mcu_req = 1; run(1); cur.mcu_req = 0; run(3);
    cur.cclr = 1; run(2); cur.cclr = 0; run(3);
    cur.vclr = 1; run(2); cur.vclr = 0; run(3);

    cur.din = 8'h5A; cur.latch = 1; run(6); cur.latch = 0; run(3);
    cur.zclr = 1; run(2); cur.zclr = 0; run(3);
    cur.din = 8'h33; cur.latch = 1; cur.zclr = 1; run(1);
    cur.latch = 0; cur.zclr = 0; run(4);

    cur.wclr = 1; run(1); cur.wclr = 0; run(1);
    for (int f = 0; f < 20; f++) begin
      frame();
      if (f % 5 == 4) begin cur.wclr = 1; run(1); cur.wclr = 0; run(1); end
    end
    for (int f = 0; f < 12; f++) frame();

    for (int i = 0; i < 2000; i++) begin
      if ($urandom_range(0, 5) == 0)  cur.vblank = ~cur.vblank;
      cur.mcu_req = ($urandom_range(0, 15) == 0);
      cur.din = 8'($urandom);
      if ($urandom_range(0, 7) == 0)  cur.latch = ~cur.latch;
      if ($urandom_range(0, 7) == 0)  cur.vclr = ~cur.vclr;
      if ($urandom_range(0, 7) == 0)  cur.cclr = ~cur.cclr;
      if ($urandom_range(0, 39) == 0) cur.wclr = ~cur.wclr;
      if ($urandom_range(0, 7) == 0)  cur.zclr = ~cur.zclr;
      run(1);
    end

    cur = '0; run(3);
    cur.din = 8'hC3; cur.latch = 1; run(2); cur.latch = 0; run(1);
    cur.vblank = 1; run(2); cur.vblank = 0; run(2);
    for (int f = 0; f < 12 && m_fire == 0; f++) frame();
    run(3);

    @(negedge clk);
    #2 reset = 1'b1;
    cur = '0;
    drive(cur);
    #1 check_reset_values();
    model_reset();
    @(negedge clk);
    reset = 1'b0;
    run(4);
    cur.mcu_req = 1; run(1); cur.mcu_req = 0; run(4);

    for (int i = 0; i < 10 && sb.size() > 0; i++) @(posedge clk);
    #2;
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard drain: %0d entries left, expected 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
